regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
- Shares the register file's single write port between num_req requesters using round-robin arbitration.
- Provides a clear sequencer that sweeps every register to zero on command, without a global reset.
- Sits between the execution/writeback units and the register file's write_en, write_addr and write_bus inputs.
- All outputs are registered.

Parameters:
word_len, 32, data width
addr_len, 5, register address width; register count = 2**addr_len
num_req, 3, number of write requesters (2..8)
protect_r0, 1, when 1, granted writes to address 0 are acknowledged but not performed

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
req  input  num_req  per-requester write request, held until granted
req_addr  input  num_req*addr_len  packed target addresses; requester i at [i*addr_len +: addr_len]
req_data  input  num_req*word_len  packed write data; requester i at [i*word_len +: word_len]
gnt  output  num_req  one-hot, one-cycle grant pulse
clr_start  input  1  request a full register clear
clr_busy  output  1  high while a clear sweep is in progress
clr_done  output  1  one-cycle pulse when the sweep completes
rf_write_en  output  1  to the register file write_en
rf_write_addr  output  addr_len  to the register file write_addr
rf_write_bus  output  word_len  to the register file write_bus

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; gnt, clr_busy, clr_done, rf_write_en, rf_write_addr and rf_write_bus all 0; clear counter 0; round-robin pointer last=num_req-1, so requester 0 has highest priority first.
- FSM states: IDLE, CLEAR, DONE.
- IDLE, clr_start=1 at a rising edge:
  - Go to CLEAR; no grant that cycle (clear has priority over requests).
  - Next cycle: rf_write_en=1, rf_write_addr=0, rf_write_bus=0, clr_busy=1.
- IDLE, clr_start=0:
  - Eligible set = req & ~gnt. Masking the current grant stops a requester whose req is still high in its grant cycle from being granted twice.
  - Winner = first eligible index scanning last+1, last+2, ... modulo num_req.
  - At the edge: gnt<=onehot(winner); rf_write_addr<=winner's addr; rf_write_bus<=winner's data; last<=winner.
  - rf_write_en<=1, except when protect_r0=1 and addr=0, where rf_write_en<=0 and gnt is still issued.
  - No eligible requester: gnt<=0, rf_write_en<=0; last unchanged.
- Latency: request sampled at edge k; gnt and the write are visible in cycle k+1; the register file commits at edge k+2.
- Throughput: one write per cycle across requesters; a single requester holding req high gets at most one grant every 2 cycles.
- CLEAR:
  - One write per cycle, addresses 0 .. 2**addr_len-1 in order, data 0, rf_write_en=1. protect_r0 does not apply.
  - gnt=0 throughout; req is ignored but not dropped (requesters keep waiting).
  - clr_start is ignored.
  - After the last address is written, go to DONE.
- DONE (one cycle): clr_done=1, clr_busy=0, rf_write_en=0, gnt=0. Arbitration is evaluated at the end of DONE, so the first grant can appear in the following cycle. Next state is IDLE.
- Clear timing for addr_len=5, clr_start sampled at edge t:
  - Cycles t+1..t+32: writes to addresses 0..31, clr_busy=1.
  - Cycle t+33: clr_done=1.
  - Cycle t+34: earliest gnt.
- Reset mid-clear: returns to IDLE immediately; no clr_done; the partial sweep is not resumed.
- Reset mid-grant: gnt and rf_write_en drop asynchronously, and that write is lost.
- req_addr and req_data of non-granted requesters are never observed on the outputs.

Test Plan:
- Reset then idle: rst low mid-cycle -> all outputs 0 asynchronously. Release with req=0 -> rf_write_en stays 0 for 10 cycles.
- Single requester: req[1]=1, addr=7, data=32'hDEADBEEF at edge k -> cycle k+1: gnt=3'b010, rf_write_en=1, addr 7, bus DEADBEEF. Drop req at k+1 -> no further grant.
- Round-robin: req=3'b111 held, each requester dropping req after its grant -> grants in order 0,1,2 on consecutive cycles. Then only req0 and req2 re-raised -> next grants 0 then 2.
- R0 protection: req[0]=1, addr 0, data 5 -> gnt[0] pulses, rf_write_en=0. Same with addr 1 -> rf_write_en=1.
- Clear with contention: clr_start at edge t while req=3'b011 -> 32 zero writes to addresses 0..31 in cycles t+1..t+32, gnt=0 throughout. clr_done at t+33. gnt=3'b001 at t+34, then 3'b010.
- Reset during clear: rst low at sweep address 12 -> clr_busy=0 immediately, clr_done never pulses. After release, a new clr_start sweeps from address 0.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter for the register file's single write port. Also runs a
// clear sequencer that writes zero to every register on command.
module regfile_port_arbiter #(
  parameter int word_len   = 32,
  parameter int addr_len   = 5,
  parameter int num_req    = 3,
  parameter bit protect_r0 = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [num_req-1:0]           req,
  input  logic [num_req*addr_len-1:0]  req_addr,
  input  logic [num_req*word_len-1:0]  req_data,
  output logic [num_req-1:0]           gnt,
  input  logic                         clr_start,
  output logic                         clr_busy,
  output logic                         clr_done,
  output logic                         rf_write_en,
  output logic [addr_len-1:0]          rf_write_addr,
  output logic [word_len-1:0]          rf_write_bus
);

  localparam int IW = $clog2(num_req);
  localparam logic [addr_len-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                             state, state_nxt;
  logic [addr_len-1:0]                clr_cnt, clr_cnt_nxt;
  logic [IW-1:0]                      last, last_nxt;
  logic [num_req-1:0]                 gnt_nxt;
  logic                               en_nxt, busy_nxt, done_nxt;
  logic [addr_len-1:0]                addr_nxt;
  logic [word_len-1:0]                bus_nxt;

  logic [num_req-1:0][addr_len-1:0]   addr_arr;
  logic [num_req-1:0][word_len-1:0]   data_arr;

  for (genvar i = 0; i < num_req; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*addr_len +: addr_len];
    assign data_arr[i] = req_data[i*word_len +: word_len];
  end

  // Masking the live grant keeps a requester from winning twice in a row
  // while its req is still high during the grant cycle.
  logic [num_req-1:0] elig;
  logic               win_vld;
  logic [IW-1:0]      win;
  logic [IW:0]        scan;

  always_comb begin
    elig    = req & ~gnt;
    win_vld = 1'b0;
    win     = '0;
    scan    = '0;
    for (int k = 1; k <= num_req; k++) begin
      scan = {1'b0, last} + (IW+1)'(k);
      if (scan >= (IW+1)'(num_req)) scan = scan - (IW+1)'(num_req);
      if (!win_vld && elig[scan[IW-1:0]]) begin
        win_vld = 1'b1;
        win     = scan[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      clr_cnt       <= '0;
      last          <= IW'(num_req - 1);
      gnt           <= '0;
      clr_busy      <= 1'b0;
      clr_done      <= 1'b0;
      rf_write_en   <= 1'b0;
      rf_write_addr <= '0;
      rf_write_bus  <= '0;
    end else begin
      state         <= state_nxt;
      clr_cnt       <= clr_cnt_nxt;
      last          <= last_nxt;
      gnt           <= gnt_nxt;
      clr_busy      <= busy_nxt;
      clr_done      <= done_nxt;
      rf_write_en   <= en_nxt;
      rf_write_addr <= addr_nxt;
      rf_write_bus  <= bus_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == LAST_ADDR) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; addr/bus hold when nothing is written.
  always_comb begin
    gnt_nxt     = '0;
    en_nxt      = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    addr_nxt    = rf_write_addr;
    bus_nxt     = rf_write_bus;
    clr_cnt_nxt = clr_cnt;
    last_nxt    = last;
    case (state)
      IDLE, DONE: begin
        if (state == IDLE && clr_start) begin
          en_nxt      = 1'b1;
          busy_nxt    = 1'b1;
          addr_nxt    = '0;
          bus_nxt     = '0;
          clr_cnt_nxt = '0;
        end else if (win_vld) begin
          gnt_nxt[win] = 1'b1;
          addr_nxt     = addr_arr[win];
          bus_nxt      = data_arr[win];
          en_nxt       = !(protect_r0 && addr_arr[win] == '0);
          last_nxt     = win;
        end
      end
      CLEAR: begin
        if (clr_cnt == LAST_ADDR) begin
          done_nxt = 1'b1;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
          addr_nxt    = clr_cnt + 1'b1;
          bus_nxt     = '0;
          en_nxt      = 1'b1;
          busy_nxt    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter: per-cycle expectations are queued
// as stimulus is driven and checked one cycle later.
module tb_regfile_port_arbiter;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*W-1:0]   req_data;
  logic [NR-1:0]     gnt;
  logic              clr_start, clr_busy, clr_done;
  logic              rf_write_en;
  logic [AW-1:0]     rf_write_addr;
  logic [W-1:0]      rf_write_bus;

  regfile_port_arbiter #(.word_len(W), .addr_len(AW), .num_req(NR), .protect_r0(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_bus(rf_write_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] gnt;
    logic          en;
    logic [AW-1:0] addr;
    logic [W-1:0]  bus;
    logic          busy;
    logic          done;
    logic          wr;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [NR-1:0] g, input logic en,
                      input logic [AW-1:0] a, input logic [W-1:0] d,
                      input logic busy, input logic done, input logic wr);
    exp_t e;
    e.gnt = g; e.en = en; e.addr = a; e.bus = d; e.busy = busy; e.done = done; e.wr = wr;
    q.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic push_idle(input string tag);
    push(tag, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    exp_t  e;
    string t;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      t = tq.pop_front();
      chk({t, ".gnt"},  64'(gnt),         64'(e.gnt));
      chk({t, ".en"},   64'(rf_write_en), 64'(e.en));
      chk({t, ".busy"}, 64'(clr_busy),    64'(e.busy));
      chk({t, ".done"}, 64'(clr_done),    64'(e.done));
      if (e.wr) begin
        chk({t, ".addr"}, 64'(rf_write_addr), 64'(e.addr));
        chk({t, ".bus"},  64'(rf_write_bus),  64'(e.bus));
      end
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
    req[i]              = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*W +: W]   = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".gnt"},  64'(gnt),           64'd0);
    chk({tag, ".en"},   64'(rf_write_en),   64'd0);
    chk({tag, ".busy"}, 64'(clr_busy),      64'd0);
    chk({tag, ".done"}, 64'(clr_done),      64'd0);
    chk({tag, ".addr"}, 64'(rf_write_addr), 64'd0);
    chk({tag, ".bus"},  64'(rf_write_bus),  64'd0);
  endtask

  task automatic sweep(input string tag, input int upto);
    clr_start = 1'b1;
    push($sformatf("%s_a0", tag), '0, 1'b1, '0, '0, 1'b1, 1'b0, 1'b1);
    tick();
    clr_start = 1'b0;
    for (int a = 1; a <= upto; a++) begin
      push($sformatf("%s_a%0d", tag, a), '0, 1'b1, AW'(a), '0, 1'b1, 1'b0, 1'b1);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; req = '0; req_addr = '0; req_data = '0; clr_start = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin push_idle($sformatf("idle%0d", i)); tick(); end

    // Round-robin from the reset pointer: 0, 1, 2, then 0 and 2 again
    set_req(0, 5'd10, 32'hA0); set_req(1, 5'd11, 32'hA1); set_req(2, 5'd12, 32'hA2);
    push("rr0", 3'b001, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b0, 1'b1); tick();
    req[0] = 1'b0;
    push("rr1", 3'b010, 1'b1, 5'd11, 32'hA1, 1'b0, 1'b0, 1'b1); tick();
    req[1] = 1'b0;
    push("rr2", 3'b100, 1'b1, 5'd12, 32'hA2, 1'b0, 1'b0, 1'b1); tick();
    req[0] = 1'b1;
    push("rr3", 3'b001, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b0, 1'b1); tick();
    req[0] = 1'b0;
    push("rr4", 3'b100, 1'b1, 5'd12, 32'hA2, 1'b0, 1'b0, 1'b1); tick();
    req = '0;
    push_idle("rr_idle"); tick();

    // Register 0 protection
    set_req(0, 5'd0, 32'd5);
    push("r0_prot", 3'b001, 1'b0, 5'd0, 32'd5, 1'b0, 1'b0, 1'b1); tick();
    req = '0;
    push_idle("r0_idle"); tick();
    set_req(0, 5'd1, 32'd5);
    push("r1_wr", 3'b001, 1'b1, 5'd1, 32'd5, 1'b0, 1'b0, 1'b1); tick();
    req = '0;
    push_idle("r1_idle"); tick();

    // Single requester
    set_req(1, 5'd7, 32'hDEADBEEF);
    push("single", 3'b010, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1); tick();
    req = '0;
    push_idle("single_idle0"); tick();
    push_idle("single_idle1"); tick();

    // Reset in the middle of a grant cycle
    set_req(2, 5'd9, 32'h99);
    push("pre_rst", 3'b100, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 1'b1); tick();
    req = '0;
    #3 rst = 1'b0;
    #1 chk_reset_outputs("rst_grant");
    @(negedge clk);
    rst = 1'b1;

    // Clear with two requesters waiting
    set_req(0, 5'd3, 32'h33); set_req(1, 5'd4, 32'h44);
    sweep("clr", 31);
    push("clr_done", '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0); tick();
    push("post_clr0", 3'b001, 1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 1'b1); tick();
    req[0] = 1'b0;
    push("post_clr1", 3'b010, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 1'b1); tick();
    req = '0;
    push_idle("post_clr_idle"); tick();

    // Reset partway through a sweep, then a fresh sweep
    sweep("part", 12);
    #3 rst = 1'b0;
    #1 chk_reset_outputs("rst_clear");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 36; i++) begin push_idle($sformatf("no_done%0d", i)); tick(); end
    sweep("full", 31);
    push("full_done", '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0); tick();
    push_idle("full_after"); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
